fft8_stage_sequencer: RTL and testbench

Control block for the 8-point radix-2 DIT FFT datapath. It walks 3 stages × 4 butterflies and, for each butterfly, issues in-place data-memory read addresses plus the twiddle-ROM address (k=0..3) to the butterfly unit. It tracks writeback addresses through a fixed-latency delay line and inserts drain cycles between stages, so each stage reads only fully written-back data. Sits between the top-level FFT control (start/done) and the data RAM, twiddle ROM and butterfly.

---
 rtl/fft8_pkg.sv | 65 ++++++
 rtl/fft8_stage_sequencer_if.sv | 31 +++
 rtl/fft8_wb_delay.sv | 42 ++++
 rtl/fft8_stage_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_fft8_stage_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared definitions for the 8-point radix-2 DIT FFT control path.
//   - transform size constants (N, LOG2N, NUM_BF, NUM_STAGES)
//   - addr_t data-address type, wb_entry_t writeback delay-line entry
//   - seq_state_t sequencer state encoding
//   - Q1.15 twiddle constants W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), k = 0..3
//   - butterfly address/twiddle helpers for stage s, butterfly j
package fft8_pkg;

  localparam int N          = 8;
  localparam int LOG2N      = 3;
  localparam int NUM_BF     = 4;
  localparam int NUM_STAGES = 3;

  typedef logic [LOG2N-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic  valid;
    addr_t a;
    addr_t b;
  } wb_entry_t;

  // Packed as {k3, k2, k1, k0}. +1.0 saturates to 0x7FFF.
  localparam logic [NUM_BF-1:0][15:0] TW_RE = {16'hA57E, 16'h0000, 16'h5A82, 16'h7FFF};
  localparam logic [NUM_BF-1:0][15:0] TW_IM = {16'hA57E, 16'h8000, 16'hA57E, 16'h0000};

  // Top-leg address: butterflies of stage s are grouped in blocks of 2*half,
  // j>>s selects the block and the low s bits of j the offset inside it.
  function automatic addr_t bf_addr_a(input logic [1:0] s, input logic [1:0] j);
    logic [3:0] half;
    logic [3:0] pos;
    logic [3:0] grp;
    logic [3:0] a;
    half = 4'd1 << s;
    pos  = {2'b00, j} & (half - 4'd1);
    grp  = {2'b00, j} >> s;
    a    = grp * (half << 1) + pos;
    return a[2:0];
  endfunction

  function automatic addr_t bf_addr_b(input logic [1:0] s, input logic [1:0] j);
    logic [3:0] half;
    addr_t      a;
    half = 4'd1 << s;
    a    = bf_addr_a(s, j);
    return a + half[2:0];
  endfunction

  function automatic logic [2:0] bf_tw(input logic [1:0] s, input logic [1:0] j);
    logic [3:0] half;
    logic [3:0] pos;
    logic [3:0] t;
    half = 4'd1 << s;
    pos  = {2'b00, j} & (half - 4'd1);
    t    = pos << (2'd2 - s);
    return t[2:0];
  endfunction

endpackage

// File: rtl/fft8_stage_sequencer_if.sv
// fft8_stage_sequencer_if: issue and writeback bus between the stage
// sequencer and the butterfly / data RAM / twiddle ROM.
//   bf_valid, bf_ready      issue handshake
//   rd_addr_a, rd_addr_b    in-place read addresses (top/bottom leg)
//   tw_addr                 twiddle ROM index 0..3
//   stage                   current stage 0..2
//   wb_valid, wb_addr_a/b   delayed writeback strobe and addresses
// master = sequencer, slave = datapath.
interface fft8_stage_sequencer_if #(parameter int AW = 3);
  logic          bf_valid;
  logic          bf_ready;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [2:0]    tw_addr;
  logic [1:0]    stage;
  logic          wb_valid;
  logic [AW-1:0] wb_addr_a;
  logic [AW-1:0] wb_addr_b;

  modport master (
    output bf_valid, rd_addr_a, rd_addr_b, tw_addr, stage,
    output wb_valid, wb_addr_a, wb_addr_b,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, rd_addr_a, rd_addr_b, tw_addr, stage,
    input  wb_valid, wb_addr_a, wb_addr_b,
    output bf_ready
  );
endinterface

// File: rtl/fft8_wb_delay.sv
// fft8_wb_delay: DEPTH-deep shift register of {valid, a, b} writeback
// entries. Shifts every cycle; the butterfly never stalls once an issue
// is accepted, so the entry leaves exactly DEPTH cycles after entering.
//   clk, rst_n  clock, async active-low clear of every entry
//   in_entry    entry loaded at the head each cycle
//   out_entry   tail entry (drives the writeback port)
module fft8_wb_delay
  import fft8_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  wb_entry_t in_entry,
  output wb_entry_t out_entry
);

  wb_entry_t pipe_q [DEPTH];
  wb_entry_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = in_entry;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign out_entry = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft8_stage_sequencer.sv
// fft8_stage_sequencer: walks 3 stages x 4 butterflies of an 8-point
// radix-2 DIT FFT, issuing in-place read addresses and twiddle index,
// tracking writebacks through a BF_LAT-deep delay line and draining
// between stages so a stage only reads fully written-back data.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          start request (ignored while busy)
//   bus (master)   issue handshake + read/twiddle/stage + writeback
//   busy           high from start acceptance until done
//   done           one-cycle completion pulse
//   inv, tw_conj   only with FFT8_SEQ_INVERSE_EN: inv is latched at start,
//                  tw_conj mirrors it while busy (IFFT twiddle conjugate)
//
// Optional feature macro: FFT8_SEQ_INVERSE_EN
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | presenting butterfly j of the current stage, advancing on accept
// DRAIN | no issue; waiting BF_LAT cycles for the stage's writebacks
// DONE  | one-cycle done pulse, then IDLE
module fft8_stage_sequencer
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2,
  parameter int AW     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef FFT8_SEQ_INVERSE_EN
  input  logic inv,
  output logic tw_conj,
`endif
  fft8_stage_sequencer_if.master bus,
  output logic busy,
  output logic done
);

  localparam int DRW = $clog2(BF_LAT + 1);

  seq_state_t    state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [1:0]    j_q, j_d;
  logic [DRW-1:0] drain_q, drain_d;
  logic          bf_valid_q, bf_valid_d;
  logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [2:0]    tw_addr_q, tw_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef FFT8_SEQ_INVERSE_EN
  logic          tw_conj_q, tw_conj_d;
`endif

  logic          accept;
  wb_entry_t     wb_in;
  wb_entry_t     wb_out;

  assign accept = bf_valid_q & bus.bf_ready;

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    j_d        = j_q;
    drain_d    = drain_q;
    bf_valid_d = bf_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef FFT8_SEQ_INVERSE_EN
    tw_conj_d  = tw_conj_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          stage_d    = 2'd0;
          j_d        = 2'd0;
          bf_valid_d = 1'b1;
          busy_d     = 1'b1;
`ifdef FFT8_SEQ_INVERSE_EN
          tw_conj_d  = inv;
`endif
        end
      end
      ISSUE: begin
        if (accept) begin
          if (j_q == 2'd3) begin
            state_d    = DRAIN;
            drain_d    = DRW'(BF_LAT);
            bf_valid_d = 1'b0;
          end else begin
            j_d = j_q + 2'd1;
          end
        end
      end
      DRAIN: begin
        // Leave when the count reaches 0 after this cycle's decrement, giving
        // exactly BF_LAT drain cycles; the stage's last writeback lands in
        // the final one.
        drain_d = drain_q - DRW'(1);
        if (drain_q == DRW'(1)) begin
          if (stage_q < 2'd2) begin
            state_d    = ISSUE;
            stage_d    = stage_q + 2'd1;
            j_d        = 2'd0;
            bf_valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`ifdef FFT8_SEQ_INVERSE_EN
            tw_conj_d = 1'b0;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Addresses are registered from the next stage/j so they line up with
    // bf_valid and stay frozen while the issue is stalled.
    if (bf_valid_d) begin
      rd_addr_a_d = AW'(bf_addr_a(stage_d, j_d));
      rd_addr_b_d = AW'(bf_addr_b(stage_d, j_d));
      tw_addr_d   = bf_tw(stage_d, j_d);
    end else begin
      rd_addr_a_d = '0;
      rd_addr_b_d = '0;
      tw_addr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      drain_q     <= '0;
      bf_valid_q  <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FFT8_SEQ_INVERSE_EN
      tw_conj_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      j_q         <= j_d;
      drain_q     <= drain_d;
      bf_valid_q  <= bf_valid_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef FFT8_SEQ_INVERSE_EN
      tw_conj_q   <= tw_conj_d;
`endif
    end
  end

  always_comb begin
    wb_in.valid = accept;
    wb_in.a     = accept ? addr_t'(rd_addr_a_q) : '0;
    wb_in.b     = accept ? addr_t'(rd_addr_b_q) : '0;
  end

  fft8_wb_delay #(.DEPTH(BF_LAT)) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_entry  (wb_in),
    .out_entry (wb_out)
  );

  assign bus.bf_valid  = bf_valid_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.stage     = stage_q;
  assign bus.wb_valid  = wb_out.valid;
  assign bus.wb_addr_a = AW'(wb_out.a);
  assign bus.wb_addr_b = AW'(wb_out.b);
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef FFT8_SEQ_INVERSE_EN
  assign tw_conj       = tw_conj_q;
`endif

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
module tb_fft8_stage_sequencer;

  localparam int BF_LAT = 2;
  localparam int AW     = 3;
  localparam int NBF    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
`ifdef FFT8_SEQ_INVERSE_EN
  logic inv = 1'b0;
  logic tw_conj;
`endif

  fft8_stage_sequencer_if #(.AW(AW)) bus ();

  fft8_stage_sequencer #(.BF_LAT(BF_LAT), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef FFT8_SEQ_INVERSE_EN
    .inv     (inv),
    .tw_conj (tw_conj),
`endif
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_inv = 1'b0;

  // Expected issue order of an 8-point radix-2 DIT transform (a, b, twiddle k).
  int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  typedef struct {
    int due;
    int a;
    int b;
    int st;
  } wb_t;
  wb_t pend[$];

  function automatic logic [20:0] all_outs();
    return {bus.bf_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.stage,
            bus.wb_valid, bus.wb_addr_a, bus.wb_addr_b, busy, done};
  endfunction

  // One full transform from a start pulse, checking issue order, handshake
  // stability, writeback timing, busy/done timing and stage overlap.
  // mode 0: bf_ready=1; 1: random bf_ready; 2: 3-cycle stall at stage 1, j=1.
  task automatic run_transform(input int mode, input bit start_mid, output int stalls_o);
    int cyc, idx, dones, stalls, hold, exp_done_cyc;
    bit prev_stall, mid_sent, exp_busy, overlap;
    logic [2:0] pa, pb, pt;
    wb_t w;
    cyc = 0; idx = 0; dones = 0; stalls = 0; hold = 0;
    prev_stall = 0; mid_sent = 0; pa = '0; pb = '0; pt = '0;
    pend.delete();
    @(posedge clk); #1;
    start = 1'b1;
    bus.bf_ready = 1'b1;
    @(posedge clk); #1;
    while (cyc <= 3 * (NBF + BF_LAT) + stalls + 2 && cyc < 300) begin
      start = 1'b0;
      if (start_mid && !mid_sent && bus.bf_valid && bus.stage == 2'd1) begin
        start = 1'b1;
        mid_sent = 1'b1;
      end
      case (mode)
        1: bus.bf_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.bf_valid && idx == 5 && hold < 3) begin
            bus.bf_ready = 1'b0;
            hold++;
          end else begin
            bus.bf_ready = 1'b1;
          end
        end
        default: bus.bf_ready = 1'b1;
      endcase
      @(negedge clk);

      if (cyc == 0) begin
        checks++;
        if (bus.bf_valid !== 1'b1) begin
          errors++;
          $display("FAIL first_issue_latency: bf_valid=%b required 1", bus.bf_valid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.bf_valid !== 1'b1 || bus.rd_addr_a !== pa || bus.rd_addr_b !== pb || bus.tw_addr !== pt) begin
          errors++;
          $display("FAIL stall_hold: v=%b a=%0d b=%0d tw=%0d required v=1 a=%0d b=%0d tw=%0d",
                   bus.bf_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, pa, pb, pt);
        end
      end
      if (bus.bf_valid) begin
        if (!bus.bf_ready) stalls++;
        checks++;
        if (idx >= 12) begin
          errors++;
          $display("FAIL extra_issue: bf_valid=1 after %0d issues required 0", idx);
        end else begin
          overlap = 1'b0;
          foreach (pend[k]) if (pend[k].st < idx / 4) overlap = 1'b1;
          if (overlap || bus.stage !== 2'(idx / 4)) begin
            errors++;
            $display("FAIL stage_issue: stage=%0d overlap=%0d required stage=%0d overlap=0",
                     bus.stage, overlap, idx / 4);
          end
          if (bus.bf_ready) begin
            checks++;
            if (bus.rd_addr_a !== 3'(exp_a[idx]) || bus.rd_addr_b !== 3'(exp_b[idx]) ||
                bus.tw_addr !== 3'(exp_tw[idx])) begin
              errors++;
              $display("FAIL issue_%0d: (%0d,%0d,%0d) required (%0d,%0d,%0d)", idx,
                       bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, exp_a[idx], exp_b[idx], exp_tw[idx]);
            end
            w.due = cyc + BF_LAT; w.a = exp_a[idx]; w.b = exp_b[idx]; w.st = idx / 4;
            pend.push_back(w);
            idx++;
          end
        end
      end
      prev_stall = bus.bf_valid && !bus.bf_ready;
      pa = bus.rd_addr_a; pb = bus.rd_addr_b; pt = bus.tw_addr;

      checks++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        w = pend.pop_front();
        if (bus.wb_valid !== 1'b1 || bus.wb_addr_a !== 3'(w.a) || bus.wb_addr_b !== 3'(w.b)) begin
          errors++;
          $display("FAIL wb_timing: v=%b a=%0d b=%0d required v=1 a=%0d b=%0d at cycle %0d",
                   bus.wb_valid, bus.wb_addr_a, bus.wb_addr_b, w.a, w.b, cyc);
        end
      end else if (bus.wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL wb_spurious: wb_valid=%b required 0 at cycle %0d", bus.wb_valid, cyc);
      end

      exp_done_cyc = 3 * (NBF + BF_LAT) + stalls;
      exp_busy = (cyc < exp_done_cyc);
      checks++;
      if (done !== (cyc == exp_done_cyc) || busy !== exp_busy || bus.stage > 2'd2 || bus.tw_addr > 3'd3) begin
        errors++;
        $display("FAIL busy_done: cycle %0d done=%b busy=%b stage=%0d tw=%0d required done=%0d busy=%0d",
                 cyc, done, busy, bus.stage, bus.tw_addr, cyc == exp_done_cyc, exp_busy);
      end
`ifdef FFT8_SEQ_INVERSE_EN
      checks++;
      if (tw_conj !== (exp_busy ? exp_inv : 1'b0)) begin
        errors++;
        $display("FAIL tw_conj: cycle %0d tw_conj=%b required %b", cyc, tw_conj, exp_busy ? exp_inv : 1'b0);
      end
`endif
      if (done) dones++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (idx != 12 || dones != 1 || pend.size() != 0) begin
      errors++;
      $display("FAIL run_summary: issues=%0d dones=%0d pending_wb=%0d required 12 1 0",
               idx, dones, pend.size());
    end
    stalls_o = stalls;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bf_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %h required 0", all_outs());
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL idle_outputs: %h required 0", all_outs());
    end
  endtask

  task automatic test_sequence();
    int st;
    run_transform(0, 1'b0, st);
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL sequence_stalls: %0d required 0", st);
    end
  endtask

  task automatic test_backpressure();
    int st;
    run_transform(2, 1'b0, st);
    checks++;
    if (st != 3) begin
      errors++;
      $display("FAIL backpressure_stalls: %0d required 3", st);
    end
  endtask

  task automatic test_random_ready();
    int st;
    for (int r = 0; r < 4; r++) run_transform(1, 1'b0, st);
  endtask

  task automatic test_start_while_busy();
    int st;
    run_transform(0, 1'b1, st);
  endtask

  task automatic test_reset_mid();
    int n;
    int st;
    @(posedge clk); #1;
    bus.bf_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.stage == 2'd2 && !bus.bf_valid && busy) break;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reset_mid_reach_drain: timeout waiting for stage 2 drain");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: %h required 0", all_outs());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.wb_valid !== 1'b0 || bus.bf_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stale: wb_valid=%b bf_valid=%b busy=%b required 0 0 0",
                 bus.wb_valid, bus.bf_valid, busy);
      end
    end
    run_transform(0, 1'b0, st);
  endtask

  task automatic test_level_start();
    int n;
    @(posedge clk); #1;
    bus.bf_ready = 1'b1;
    start = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL level_start_first_done: timeout");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.bf_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL level_start_idle: busy=%b bf_valid=%b done=%b required 0 0 0", busy, bus.bf_valid, done);
    end
    @(negedge clk);
    checks++;
    if (bus.bf_valid !== 1'b1 || busy !== 1'b1 || bus.stage !== 2'd0 ||
        bus.rd_addr_a !== 3'd0 || bus.rd_addr_b !== 3'd1) begin
      errors++;
      $display("FAIL level_start_restart: v=%b busy=%b stage=%0d a=%0d b=%0d required 1 1 0 0 1",
               bus.bf_valid, busy, bus.stage, bus.rd_addr_a, bus.rd_addr_b);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL level_start_second_done: timeout");
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef FFT8_SEQ_INVERSE_EN
  task automatic test_inverse();
    int st;
    inv = 1'b1;
    exp_inv = 1'b1;
    run_transform(0, 1'b0, st);
    inv = 1'b0;
    exp_inv = 1'b0;
  endtask
`endif

  initial begin
    bus.bf_ready = 1'b0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid();
    test_level_start();
`ifdef FFT8_SEQ_INVERSE_EN
    test_inverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
